// File: rtl/fp_mul_seq.sv
// Sequential IEEE-754 multiplier: radix-2 shift-and-add significand datapath,
// with a fast path for NaN, infinity and zero operands.
package fp_flags_pkg;
  localparam int NRAS                = 4;
  localparam int roundTiesToEven     = 0;
  localparam int roundTowardZero     = 1;
  localparam int roundTowardPositive = 2;
  localparam int roundTowardNegative = 3;
  localparam int roundTiesToAway     = 4;

  localparam int NTYPES    = 6;
  localparam int SNAN      = 0;
  localparam int QNAN      = 1;
  localparam int INFINITY  = 2;
  localparam int ZERO      = 3;
  localparam int SUBNORMAL = 4;
  localparam int NORMAL    = 5;

  localparam int NEXCEPTIONS  = 5;
  localparam int INVALID      = 0;
  localparam int DIVIDEBYZERO = 1;
  localparam int OVERFLOW     = 2;
  localparam int UNDERFLOW    = 3;
  localparam int INEXACT      = 4;
endpackage

module fp_mul_seq
  import fp_flags_pkg::*;
#(
  parameter int NEXP = 5,
  parameter int NSIG = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [NEXP+NSIG:0]     a,
  input  logic [NEXP+NSIG:0]     b,
  input  logic [NRAS:0]          ra,
  output logic [NEXP+NSIG:0]     p,
  output logic [NTYPES-1:0]      pFlags,
  output logic [NEXCEPTIONS-1:0] exception,
  output logic                   done
);
  localparam int W    = NEXP + NSIG + 1;
  localparam int SW   = NSIG + 1;
  localparam int PW   = 2 * SW;
  localparam int EW   = NEXP + 5;
  localparam int CW   = $clog2(SW + 1);
  localparam int LW   = $clog2(PW);
  localparam int XW   = 2 * PW + 2;
  localparam int BIAS = (1 << (NEXP - 1)) - 1;
  localparam logic [NEXP-1:0] EXP_ONES = '1;

  typedef enum logic [2:0] {S_IDLE, S_CLASSIFY, S_MUL, S_NORM, S_ROUND, S_DONE} state_t;
  typedef struct packed { logic nan, snan, inf, zero; } op_class_t;

  function automatic op_class_t decode(input logic [W-1:0] x);
    logic emax, fz;
    emax = &x[W-2:NSIG];
    fz   = ~|x[NSIG-1:0];
    decode.nan  = emax & ~fz;
    decode.snan = emax & ~fz & ~x[NSIG-1];
    decode.inf  = emax & fz;
    decode.zero = ~|x[W-2:NSIG] & fz;
  endfunction

  function automatic logic [NTYPES-1:0] classify(input logic [W-1:0] x);
    op_class_t c;
    c = decode(x);
    classify = '0;
    if (c.snan)                 classify[SNAN]      = 1'b1;
    else if (c.nan)             classify[QNAN]      = 1'b1;
    else if (c.inf)             classify[INFINITY]  = 1'b1;
    else if (c.zero)            classify[ZERO]      = 1'b1;
    else if (~|x[W-2:NSIG])     classify[SUBNORMAL] = 1'b1;
    else                        classify[NORMAL]    = 1'b1;
  endfunction

  state_t                  r_state, w_next;
  logic [W-1:0]            r_a, r_b, r_res_p, r_p;
  logic [NRAS:0]           r_ra;
  logic                    r_sign, r_g, r_r, r_s, r_tiny, r_fin, r_done;
  logic [SW-1:0]           r_ma, r_mb, r_sig;
  logic [PW-1:0]           r_acc;
  logic [CW-1:0]           r_cnt;
  logic signed [EW-1:0]    r_exp;
  logic [NEXCEPTIONS-1:0]  r_res_exc, r_exc;
  logic [NTYPES-1:0]       r_flags;

  logic                    w_capture, w_publish, w_mul_last;
  op_class_t               w_ca, w_cb;
  logic                    w_sign, w_special;
  logic [W-1:0]            w_sp_p;
  logic [NEXCEPTIONS-1:0]  w_sp_exc;
  logic [NEXP-1:0]         w_ea, w_eb;
  logic signed [EW-1:0]    w_exp0;

  assign w_ca   = decode(r_a);
  assign w_cb   = decode(r_b);
  assign w_sign = r_a[W-1] ^ r_b[W-1];
  assign w_ea   = (~|r_a[W-2:NSIG]) ? NEXP'(1) : r_a[W-2:NSIG];
  assign w_eb   = (~|r_b[W-2:NSIG]) ? NEXP'(1) : r_b[W-2:NSIG];
  assign w_exp0 = EW'(w_ea) + EW'(w_eb) - EW'(BIAS - 1);

  // NOTE: every variable written in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    w_special = 1'b1;
    w_sp_p    = '0;
    w_sp_exc  = '0;
    if (w_ca.nan || w_cb.nan) begin
      w_sp_p             = w_ca.nan ? r_a : r_b;
      w_sp_p[NSIG-1]     = 1'b1;
      w_sp_exc[INVALID]  = w_ca.snan | w_cb.snan;
    end else if ((w_ca.zero && w_cb.inf) || (w_ca.inf && w_cb.zero)) begin
      w_sp_p             = {1'b0, EXP_ONES, 1'b1, {(NSIG-1){1'b0}}};
      w_sp_exc[INVALID]  = 1'b1;
    end else if (w_ca.inf || w_cb.inf) begin
      w_sp_p = {w_sign, EXP_ONES, {NSIG{1'b0}}};
    end else if (w_ca.zero || w_cb.zero) begin
      w_sp_p = {w_sign, {(W-1){1'b0}}};
    end else begin
      w_special = 1'b0;
    end
  end

  // Shift-and-add step: conditional add into the upper half, then shift right.
  logic [SW:0]   w_sum;
  logic [PW-1:0] w_acc_next;
  assign w_sum      = {1'b0, r_acc[PW-1:SW]} + (r_mb[0] ? {1'b0, r_ma} : '0);
  assign w_acc_next = {w_sum, r_acc[SW-1:1]};

  logic [LW-1:0]        w_lz;
  logic [PW-1:0]        w_norm, w_den;
  logic signed [EW-1:0] w_exp_n;
  logic [EW-1:0]        w_sh;
  logic [XW-1:0]        w_shx;
  logic                 w_tiny, w_lost;

  always_comb begin
    w_lz = '0;
    for (int i = 0; i < PW; i++)
      if (r_acc[i]) w_lz = LW'(PW - 1 - i);
    w_norm  = r_acc << w_lz;
    w_exp_n = r_exp - $signed(EW'(w_lz));
    w_tiny  = (w_exp_n < 1);
    w_sh    = w_tiny ? (EW'(1) - w_exp_n) : '0;
    if (w_sh > EW'(PW + 2)) w_sh = EW'(PW + 2);
    w_shx   = {w_norm, {(PW+2){1'b0}}} >> w_sh;
    w_den   = w_shx[XW-1 -: PW];
    w_lost  = |w_shx[PW+1:0];
  end

  logic                   w_half, w_st, w_inexact, w_inc, w_ovf, w_to_max;
  logic [EW+NSIG-1:0]     w_mag;
  logic [W-1:0]           w_rnd_p;
  logic [NEXCEPTIONS-1:0] w_rnd_exc;

  always_comb begin
    w_half    = r_g;
    w_st      = r_r | r_s;
    w_inexact = w_half | w_st;
    if (r_ra[roundTiesToEven])          w_inc = w_half & (w_st | r_sig[0]);
    else if (r_ra[roundTiesToAway])     w_inc = w_half;
    else if (r_ra[roundTowardPositive]) w_inc = w_inexact & ~r_sign;
    else if (r_ra[roundTowardNegative]) w_inc = w_inexact & r_sign;
    else if (r_ra[roundTowardZero])     w_inc = 1'b0;
    else                                w_inc = w_half & (w_st | r_sig[0]);
    // Exponent and fraction add as one field, so a significand carry bumps the exponent.
    w_mag     = {r_exp, r_sig[NSIG-1:0]} + (EW+NSIG)'(w_inc);
    w_ovf     = (w_mag[EW+NSIG-1:NSIG] >= {{(EW-NEXP){1'b0}}, EXP_ONES});
    w_to_max  = r_ra[roundTowardZero] | (r_ra[roundTowardPositive] & r_sign)
              | (r_ra[roundTowardNegative] & ~r_sign);
    w_rnd_exc = '0;
    if (w_ovf) begin
      w_rnd_p              = w_to_max ? {r_sign, EXP_ONES - 1'b1, {NSIG{1'b1}}}
                                      : {r_sign, EXP_ONES, {NSIG{1'b0}}};
      w_rnd_exc[OVERFLOW]  = 1'b1;
      w_rnd_exc[INEXACT]   = 1'b1;
    end else begin
      w_rnd_p              = {r_sign, w_mag[NEXP+NSIG-1:0]};
      w_rnd_exc[INEXACT]   = w_inexact;
      w_rnd_exc[UNDERFLOW] = r_tiny & w_inexact;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_next = S_CLASSIFY;
      S_CLASSIFY:     w_next = w_special ? S_ROUND : S_MUL;
      S_MUL:          if (w_mul_last) w_next = S_NORM;
      S_NORM:         w_next = S_ROUND;
      S_ROUND:        if (r_fin) w_next = S_DONE;
      default:        w_next = S_IDLE;
    endcase
  end

  // Special results are staged in ROUND with r_fin already set, so both paths publish identically.
  always_comb begin
    w_capture  = start && (r_state == S_IDLE || r_state == S_DONE);
    w_publish  = (r_state == S_ROUND) && r_fin;
    w_mul_last = (r_state == S_MUL) && (r_cnt == CW'(1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_p     <= '0;
      r_flags <= '0;
      r_exc   <= '0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (w_capture) r_done <= 1'b0;
      if (w_publish) begin
        r_p     <= r_res_p;
        r_flags <= classify(r_res_p);
        r_exc   <= r_res_exc;
        r_done  <= 1'b1;
      end
      if (r_state == S_CLASSIFY) r_cnt <= CW'(SW);
      else if (r_state == S_MUL) r_cnt <= r_cnt - 1'b1;
    end
  end

  // NOTE: datapath registers carry no reset; each is written before it is read in every operation.
  always_ff @(posedge clk) begin
    case (r_state)
      S_IDLE, S_DONE: if (start) begin
        r_a  <= a;
        r_b  <= b;
        r_ra <= ra;
      end
      S_CLASSIFY: begin
        r_sign    <= w_sign;
        r_ma      <= {|r_a[W-2:NSIG], r_a[NSIG-1:0]};
        r_mb      <= {|r_b[W-2:NSIG], r_b[NSIG-1:0]};
        r_acc     <= '0;
        r_exp     <= w_exp0;
        r_res_p   <= w_sp_p;
        r_res_exc <= w_sp_exc;
        r_fin     <= w_special;
      end
      S_MUL: begin
        r_acc <= w_acc_next;
        r_mb  <= r_mb >> 1;
      end
      S_NORM: begin
        r_sig  <= w_den[PW-1 -: SW];
        r_g    <= w_den[SW-1];
        r_r    <= w_den[SW-2];
        r_s    <= |w_den[SW-3:0] | w_lost;
        r_tiny <= w_tiny;
        r_exp  <= w_tiny ? '0 : w_exp_n;
      end
      S_ROUND: if (!r_fin) begin
        r_res_p   <= w_rnd_p;
        r_res_exc <= w_rnd_exc;
        r_fin     <= 1'b1;
      end
      default: ;
    endcase
  end

  assign p         = r_p;
  assign pFlags    = r_flags;
  assign exception = r_exc;
  assign done      = r_done;
endmodule
